// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Holds the controller state encoding and the default operand width.
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter must be able to hold every value 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: diff = a ^ b ^ bin, borrow out when a < b + bin.
// Purely combinational; no handshake.
module full_subtractor_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic diff_o,
   output logic bout_o
);

   assign diff_o = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first; result valid WIDTH+1 edges after accept, held until out_ready_i.
// Optional signed-overflow output ovf_o when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_OVF_EN
   output logic             bout_o,
   output logic             ovf_o
`else
   output logic             bout_o
`endif
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] ad_sr;
   logic [WIDTH-1:0] b_sr;
   logic             br;
   logic             br_nxt;
   logic             d;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   full_subtractor_cell u_cell (
      .a_i    (ad_sr[0]),
      .b_i    (b_sr[0]),
      .bin_i  (br),
      .diff_o (d),
      .bout_o (br_nxt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ready depends on state only, so out_ready_i never reaches in_ready_o.
   always_comb begin
      state_nxt   = state;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The minuend register doubles as the difference shift register: each
   // consumed a bit leaves the LSB while the new difference bit enters the MSB.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ad_sr  <= '0;
         b_sr   <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_o <= '0;
         bout_o <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_o  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  ad_sr <= a_i;
                  b_sr  <= b_i;
                  br    <= bin_i;
                  cnt   <= '0;
               end
            end
            RUN: begin
               ad_sr <= {d, ad_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               br    <= br_nxt;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  diff_o <= {d, ad_sr[WIDTH-1:1]};
                  bout_o <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_o  <= br ^ br_nxt;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8; ovf checks compiled in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       bin_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       bout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int   checks = 0;
   int   passed = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a_in),
      .b_i         (b_in),
      .bin_i       (bin_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .diff_o      (diff),
`ifdef SERIAL_SUB_OVF_EN
      .bout_o      (bout),
      .ovf_o       (ovf)
`else
      .bout_o      (bout)
`endif
   );

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
      exp_t       r;
      logic [8:0] full;
      logic [7:0] low;
      full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
      low  = {1'b0, a[6:0]} - {1'b0, b[6:0]} - {7'd0, bi};
      r.d  = full[7:0];
      r.bo = full[8];
      r.ov = low[7] ^ full[8];
      return r;
   endfunction

   function automatic logic [7:0] pick_operand();
      case ($urandom_range(0, 3))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic bi, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) return;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      bin_in   = bi;
      q.push_back(model(a, b, bi));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      ok = 1'b1;
   endtask

   // Waits for a result, stalls the consumer, samples the outputs, then consumes.
   task automatic recv_result(input int stall, output logic [7:0] d, output logic bo,
                              output logic ov, output bit ok);
      int n = 0;
      ok = 1'b0;
      d  = 'x;
      bo = 1'bx;
      ov = 1'bx;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) return;
      repeat (stall) @(negedge clk);
      d  = diff;
      bo = bout;
`ifdef SERIAL_SUB_OVF_EN
      ov = ovf;
`else
      ov = 1'b0;
`endif
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      a_in      = 8'hAB;
      b_in      = 8'h01;
      bin_in    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      checks++; if (diff !== 8'h00) $display("FAIL reset_diff got %h want 00", diff); else passed++;
      checks++; if (bout !== 1'b0) $display("FAIL reset_bout got %b want 0", bout); else passed++;
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
`endif
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      bit         ok;
      int         lat;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      exp_t       e;
      logic [7:0] av[3] = '{8'h05, 8'h00, 8'h10};
      logic [7:0] bv[3] = '{8'h03, 8'h01, 8'h0F};
      logic       iv[3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] dv[3] = '{8'h02, 8'hFF, 8'h00};
      logic       ov_b[3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         send_op(av[i], bv[i], iv[i], ok);
         if (!ok) begin
            checks++; $display("FAIL basic_accept got timeout want accept op=%0d", i);
            continue;
         end
         // lat = edge, counted from the accept edge, at which the result is first consumable
         lat = 1;
         while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         if (i == 0) begin
            checks++; if (lat !== 9) $display("FAIL basic_latency got %0d want 9", lat); else passed++;
         end
         recv_result(0, d, bo, ov, ok);
         e = q.pop_front();
         checks++; if (!ok || d !== dv[i]) $display("FAIL basic_diff op=%0d got %h want %h", i, d, dv[i]); else passed++;
         checks++; if (!ok || bo !== ov_b[i]) $display("FAIL basic_bout op=%0d got %b want %b", i, bo, ov_b[i]); else passed++;
         checks++; if (d !== e.d || bo !== e.bo) $display("FAIL basic_model op=%0d got %h/%b want %h/%b", i, d, bo, e.d, e.bo); else passed++;
      end
   endtask

   task automatic test_signed_edges();
      bit         ok;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      exp_t       e;
      logic [7:0] av[2] = '{8'h80, 8'h7F};
      logic [7:0] bv[2] = '{8'h01, 8'hFF};
      logic [7:0] dv[2] = '{8'h7F, 8'h80};
      logic       bov[2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         send_op(av[i], bv[i], 1'b0, ok);
         recv_result(1, d, bo, ov, ok);
         e = q.pop_front();
         checks++; if (!ok || d !== dv[i]) $display("FAIL signed_diff op=%0d got %h want %h", i, d, dv[i]); else passed++;
         checks++; if (!ok || bo !== bov[i]) $display("FAIL signed_bout op=%0d got %b want %b", i, bo, bov[i]); else passed++;
`ifdef SERIAL_SUB_OVF_EN
         checks++; if (!ok || ov !== 1'b1) $display("FAIL signed_ovf op=%0d got %b want 1", i, ov); else passed++;
         checks++; if (ov !== e.ov) $display("FAIL signed_ovf_model op=%0d got %b want %b", i, ov, e.ov); else passed++;
`endif
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      int   n = 0;
      exp_t e;
      send_op(8'h3C, 8'h5A, 1'b1, ok);
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      e = q.pop_front();
      checks++; if (out_valid !== 1'b1) $display("FAIL stall_wait got out_valid=%b want 1", out_valid); else passed++;
      for (int i = 0; i < 5; i++) begin
         in_valid = ~i[0];
         a_in     = 8'($urandom_range(0, 255));
         @(negedge clk);
         checks++;
         if (diff !== e.d || bout !== e.bo || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL stall_hold cyc=%0d got diff=%h bout=%b rdy=%b vld=%b want diff=%h bout=%b rdy=0 vld=1",
                     i, diff, bout, in_ready, out_valid, e.d, e.bo);
         else passed++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL stall_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      bit         ok;
      int         seen = 0;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      exp_t       e;
      send_op(8'h12, 8'h34, 1'b0, ok);
      void'(q.pop_back());
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) $display("FAIL abort_no_output got %0d valid cycles want 0", seen); else passed++;
      checks++; if (diff !== 8'h00 || bout !== 1'b0) $display("FAIL abort_cleared got %h/%b want 00/0", diff, bout); else passed++;
      send_op(8'hAA, 8'h55, 1'b0, ok);
      recv_result(0, d, bo, ov, ok);
      e = q.pop_front();
      checks++; if (!ok || d !== 8'h55 || bo !== 1'b0) $display("FAIL abort_next got %h/%b want 55/0", d, bo); else passed++;
      checks++; if (d !== e.d) $display("FAIL abort_next_model got %h want %h", d, e.d); else passed++;
   endtask

   task automatic test_random();
      bit         ok;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      exp_t       e;
      for (int i = 0; i < 1000; i++) begin
         send_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), ok);
         if (!ok) begin
            checks++; $display("FAIL rand_accept op=%0d got timeout want accept", i);
            break;
         end
         recv_result(int'($urandom_range(0, 3)), d, bo, ov, ok);
         e = q.pop_front();
         checks++; if (!ok || d !== e.d) $display("FAIL rand_diff op=%0d got %h want %h", i, d, e.d); else passed++;
         checks++; if (!ok || bo !== e.bo) $display("FAIL rand_bout op=%0d got %b want %b", i, bo, e.bo); else passed++;
`ifdef SERIAL_SUB_OVF_EN
         checks++; if (!ok || ov !== e.ov) $display("FAIL rand_ovf op=%0d got %b want %b", i, ov, e.ov); else passed++;
`endif
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_signed_edges();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
